// File: rtl/breakout_pkg.sv
// Shared encodings for the Breakout control path: game run state and
// per-direction button repeat state.
package breakout_pkg;

   localparam int unsigned GS_W = 2;

   typedef enum logic [GS_W-1:0] {
      GS_IDLE  = 2'd0,
      GS_RUN   = 2'd1,
      GS_PAUSE = 2'd2
   } game_state_e;

   typedef enum logic [1:0] {
      RP_REL  = 2'd0,
      RP_HOLD = 2'd1,
      RP_RPT  = 2'd2
   } rpt_state_e;

endpackage

// File: rtl/btn_repeat.sv
// Edge detect plus hold-to-repeat sequencer for one direction button.
// The strobe is combinational; the parent registers and gates it.
module btn_repeat
   import breakout_pkg::*;
#(
   parameter int unsigned HOLD_DELAY    = 20,
   parameter int unsigned REPEAT_PERIOD = 5,
   parameter int unsigned CNT_W         = 17
) (
   input  logic CLK,
   input  logic RST_N,
   input  logic btn,
   output logic strobe
);

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_DELAY - 1);
   localparam logic [CNT_W-1:0] RPT_LAST  = CNT_W'(REPEAT_PERIOD - 1);

   logic             prev_q, prev_d;
   rpt_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             rise;

   always_comb begin
      rise    = btn & ~prev_q;
      prev_d  = btn;
      state_d = state_q;
      cnt_d   = cnt_q;
      strobe  = 1'b0;
      if (!btn) begin
         state_d = RP_REL;
         cnt_d   = '0;
      end else begin
         case (state_q)
            RP_REL: begin
               if (rise) begin
                  strobe  = 1'b1;
                  cnt_d   = '0;
                  state_d = RP_HOLD;
               end
            end
            RP_HOLD: begin
               if (cnt_q == HOLD_LAST) begin
                  strobe  = 1'b1;
                  cnt_d   = '0;
                  state_d = RP_RPT;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            RP_RPT: begin
               if (cnt_q == RPT_LAST) begin
                  strobe = 1'b1;
                  cnt_d  = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            default: begin
               state_d = RP_REL;
               cnt_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         prev_q  <= 1'b0;
         state_q <= RP_REL;
         cnt_q   <= '0;
      end else begin
         prev_q  <= prev_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: rtl/paddle_input_ctrl.sv
// Turns debounced button levels into paddle move strobes and the
// idle/run/pause game state that gates them.
module paddle_input_ctrl
   import breakout_pkg::*;
#(
   parameter int unsigned HOLD_DELAY    = 20,
   parameter int unsigned REPEAT_PERIOD = 5,
   parameter int unsigned CNT_W         = 17
) (
   input  logic            CLK,
   input  logic            RST_N,
   input  logic            btn_left,
   input  logic            btn_right,
   input  logic            btn_start,
   input  logic            game_over,
   output logic            move_left,
   output logic            move_right,
   output logic            start_pulse,
   output logic [GS_W-1:0] game_state
);

   logic        left_strobe, right_strobe;
   logic        start_prev_q, start_prev_d;
   game_state_e game_state_q, game_state_d;
   logic        start_pulse_q, start_pulse_d;
   logic        move_left_q, move_left_d;
   logic        move_right_q, move_right_d;
   logic        start_rise, in_run, conflict;

   btn_repeat #(
      .HOLD_DELAY   (HOLD_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD),
      .CNT_W        (CNT_W)
   ) u_rep_left (
      .CLK   (CLK),
      .RST_N (RST_N),
      .btn   (btn_left),
      .strobe(left_strobe)
   );

   btn_repeat #(
      .HOLD_DELAY   (HOLD_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD),
      .CNT_W        (CNT_W)
   ) u_rep_right (
      .CLK   (CLK),
      .RST_N (RST_N),
      .btn   (btn_right),
      .strobe(right_strobe)
   );

   always_comb begin
      start_rise    = btn_start & ~start_prev_q;
      start_prev_d  = btn_start;
      game_state_d  = game_state_q;
      start_pulse_d = 1'b0;
      case (game_state_q)
         GS_IDLE: begin
            if (start_rise) begin
               game_state_d  = GS_RUN;
               start_pulse_d = 1'b1;
            end
         end
         GS_RUN: begin
            // Losing the ball outranks a pause request in the same cycle.
            if (game_over) begin
               game_state_d = GS_IDLE;
            end else if (start_rise) begin
               game_state_d  = GS_PAUSE;
               start_pulse_d = 1'b1;
            end
         end
         GS_PAUSE: begin
            if (start_rise) begin
               game_state_d  = GS_RUN;
               start_pulse_d = 1'b1;
            end
         end
         default: game_state_d = GS_IDLE;
      endcase

      // Gate on the state before this edge's transition.
      in_run       = (game_state_q == GS_RUN);
      conflict     = btn_left & btn_right;
      move_left_d  = left_strobe & in_run & ~conflict;
      move_right_d = right_strobe & in_run & ~conflict;
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         start_prev_q  <= 1'b0;
         game_state_q  <= GS_IDLE;
         start_pulse_q <= 1'b0;
         move_left_q   <= 1'b0;
         move_right_q  <= 1'b0;
      end else begin
         start_prev_q  <= start_prev_d;
         game_state_q  <= game_state_d;
         start_pulse_q <= start_pulse_d;
         move_left_q   <= move_left_d;
         move_right_q  <= move_right_d;
      end
   end

   assign move_left   = move_left_q;
   assign move_right  = move_right_q;
   assign start_pulse = start_pulse_q;
   assign game_state  = game_state_q;

endmodule

// File: tb/tb_paddle_input_ctrl.sv
// Bench for paddle_input_ctrl: table vectors plus hand-written multi-cycle
// sequences, all routed through an expected-output queue.
module tb_paddle_input_ctrl;

   localparam int HD = 20;
   localparam int RP = 5;

   logic       CLK = 1'b0;
   logic       RST_N = 1'b0;
   logic       btn_left = 1'b0, btn_right = 1'b0, btn_start = 1'b0, game_over = 1'b0;
   logic       move_left, move_right, start_pulse;
   logic [1:0] game_state;

   paddle_input_ctrl #(
      .HOLD_DELAY   (HD),
      .REPEAT_PERIOD(RP),
      .CNT_W        (17)
   ) dut (
      .CLK        (CLK),
      .RST_N      (RST_N),
      .btn_left   (btn_left),
      .btn_right  (btn_right),
      .btn_start  (btn_start),
      .game_over  (game_over),
      .move_left  (move_left),
      .move_right (move_right),
      .start_pulse(start_pulse),
      .game_state (game_state)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic       ml;
      logic       mr;
      logic       sp;
      logic [1:0] gs;
   } out_t;

   typedef struct {
      logic l, r, s, go;
      out_t e;
   } vec_t;

   out_t sb_q[$];
   int   errors = 0;
   int   checks = 0;

   // Reference model: hold counts are posedges since the press edge, -1 when released.
   int         m_hl = -1, m_hr = -1;
   logic       m_ps = 1'b0;
   logic [1:0] m_gs = 2'd0;

   function automatic int next_h(input logic b, input int h);
      if (!b) return -1;
      if (h < 0) return 0;
      return h + 1;
   endfunction

   function automatic logic strobe_of(input logic b, input int h);
      if (!b) return 1'b0;
      return (h == 0) || (h == HD) || (h > HD && ((h - HD) % RP) == 0);
   endfunction

   task automatic model_step(input logic l, r, s, go, output out_t e);
      int hl, hr;
      logic run, se;
      hl = next_h(l, m_hl);
      hr = next_h(r, m_hr);
      run = (m_gs == 2'd1);
      e.ml = strobe_of(l, hl) && run && !(l && r);
      e.mr = strobe_of(r, hr) && run && !(l && r);
      se = s && !m_ps;
      e.sp = 1'b0;
      e.gs = m_gs;
      if (m_gs == 2'd0) begin
         if (se) begin e.gs = 2'd1; e.sp = 1'b1; end
      end else if (m_gs == 2'd1) begin
         if (go) e.gs = 2'd0;
         else if (se) begin e.gs = 2'd2; e.sp = 1'b1; end
      end else begin
         if (se) begin e.gs = 2'd1; e.sp = 1'b1; end
      end
      m_hl = hl;
      m_hr = hr;
      m_ps = s;
      m_gs = e.gs;
   endtask

   task automatic compare_pop(input string name);
      out_t act, exp;
      act = {move_left, move_right, start_pulse, game_state};
      if (sb_q.size() == 0) begin
         errors++;
         $display("FAIL %s: scoreboard empty, got %b", name, act);
      end else begin
         exp = sb_q.pop_front();
         checks++;
         if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got {ml,mr,sp,gs}=%b expected %b", name, $time, act, exp);
         end
      end
   endtask

   task automatic cycle(input logic l, r, s, go, input logic use_tab, input out_t tab_e,
                        input string name);
      out_t e;
      btn_left = l; btn_right = r; btn_start = s; game_over = go;
      model_step(l, r, s, go, e);
      sb_q.push_back(use_tab ? tab_e : e);
      @(posedge CLK);
      #1;
      compare_pop(name);
   endtask

   task automatic step(input logic l, r, s, go);
      cycle(l, r, s, go, 1'b0, '0, "seq");
   endtask

   task automatic check_val(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic apply_reset(input logic hold_start);
      RST_N = 1'b0;
      btn_left = 1'b0; btn_right = 1'b0; game_over = 1'b0; btn_start = hold_start;
      #1;
      sb_q.push_back('0);
      compare_pop("reset_outputs");
      m_hl = -1; m_hr = -1; m_ps = 1'b0; m_gs = 2'd0;
      repeat (2) @(posedge CLK);
      #1;
      RST_N = 1'b1;
   endtask

   vec_t vecs[18];
   int   hold_exp[5];
   int   idx[$];
   int   cnt_a, cnt_b, first_ml;

   initial begin
      vecs[0]  = '{0,0,0,0, '{0,0,0,2'd0}};
      vecs[1]  = '{0,0,1,0, '{0,0,1,2'd1}};
      vecs[2]  = '{0,0,1,0, '{0,0,0,2'd1}};
      vecs[3]  = '{0,0,1,0, '{0,0,0,2'd1}};
      vecs[4]  = '{0,0,0,0, '{0,0,0,2'd1}};
      vecs[5]  = '{1,0,0,0, '{1,0,0,2'd1}};
      vecs[6]  = '{1,0,0,0, '{0,0,0,2'd1}};
      vecs[7]  = '{1,0,0,0, '{0,0,0,2'd1}};
      vecs[8]  = '{0,0,0,0, '{0,0,0,2'd1}};
      vecs[9]  = '{0,1,0,0, '{0,1,0,2'd1}};
      vecs[10] = '{0,0,0,0, '{0,0,0,2'd1}};
      vecs[11] = '{0,1,0,0, '{0,1,0,2'd1}};
      vecs[12] = '{0,0,0,0, '{0,0,0,2'd1}};
      vecs[13] = '{0,0,1,0, '{0,0,1,2'd2}};
      vecs[14] = '{0,0,0,0, '{0,0,0,2'd2}};
      vecs[15] = '{1,0,0,0, '{0,0,0,2'd2}};
      vecs[16] = '{0,0,1,0, '{0,0,1,2'd1}};
      vecs[17] = '{0,0,0,0, '{0,0,0,2'd1}};
      hold_exp = '{0, 20, 25, 30, 35};

      apply_reset(1'b0);
      for (int i = 0; i < 18; i++)
         cycle(vecs[i].l, vecs[i].r, vecs[i].s, vecs[i].go, 1'b1, vecs[i].e, $sformatf("vec%0d", i));

      // Hold right 40 cycles in RUN.
      idx.delete();
      for (int i = 0; i < 40; i++) begin
         step(0, 1, 0, 0);
         if (move_right) idx.push_back(i);
      end
      check_val("hold_strobe_count", idx.size(), 5);
      for (int j = 0; j < 5; j++)
         check_val($sformatf("hold_strobe_idx%0d", j), (j < idx.size()) ? idx[j] : -1, hold_exp[j]);
      cnt_a = 0;
      for (int i = 0; i < 5; i++) begin
         step(0, 0, 0, 0);
         cnt_a += int'(move_right);
      end
      check_val("no_strobe_after_release", cnt_a, 0);

      // PAUSE gates direction strobes.
      step(0, 0, 1, 0);
      step(0, 0, 0, 0);
      check_val("paused_state", game_state, 2);
      cnt_a = 0;
      for (int i = 0; i < 30; i++) begin
         step(1, 0, 0, 0);
         cnt_a += int'(move_left) + int'(move_right);
      end
      check_val("pause_gated_moves", cnt_a, 0);
      step(0, 0, 0, 0);
      step(0, 0, 1, 0);
      check_val("resume_run", game_state, 1);
      step(0, 0, 0, 0);

      // Both directions held: silence, then left resumes on its own schedule.
      cnt_a = 0; cnt_b = 0; first_ml = -1;
      for (int i = 0; i < 40; i++) begin
         step(1, (i >= 15 && i < 30), 0, 0);
         if (i >= 15 && i < 30) cnt_a += int'(move_left) + int'(move_right);
         cnt_b += int'(move_right);
         if (i >= 30 && move_left && first_ml < 0) first_ml = i;
      end
      check_val("conflict_silent", cnt_a, 0);
      check_val("conflict_no_right", cnt_b, 0);
      check_val("left_resume_idx", first_ml, 30);
      step(0, 0, 0, 0);

      // game_over beats a start edge in RUN; ignored in PAUSE.
      step(0, 0, 1, 1);
      check_val("gameover_state", game_state, 0);
      check_val("gameover_no_pulse", start_pulse, 0);
      step(0, 0, 0, 0);
      step(0, 0, 1, 0);
      check_val("restart_state", game_state, 1);
      check_val("restart_pulse", start_pulse, 1);
      step(0, 0, 0, 0);
      step(0, 0, 1, 0);
      step(0, 0, 0, 1);
      check_val("pause_ignores_gameover", game_state, 2);
      step(0, 0, 1, 0);
      step(0, 0, 0, 0);

      // Strobe on the edge leaving RUN is emitted; on the edge entering RUN suppressed.
      step(1, 0, 1, 0);
      check_val("leave_run_strobe", move_left, 1);
      check_val("leave_run_state", game_state, 2);
      step(0, 0, 0, 0);
      step(0, 0, 1, 0);
      step(0, 0, 0, 1);
      check_val("idle_after_gameover", game_state, 0);
      step(1, 0, 1, 0);
      check_val("enter_run_suppressed", move_left, 0);
      check_val("enter_run_state", game_state, 1);
      step(0, 0, 0, 0);

      // Mid-run reset with start held through release: edge at first posedge.
      step(0, 1, 0, 0);
      apply_reset(1'b1);
      step(0, 0, 1, 0);
      check_val("held_start_after_reset", start_pulse, 1);
      check_val("held_start_state", game_state, 1);
      step(0, 0, 0, 0);
      step(1, 0, 0, 0);
      step(0, 0, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
